ifetch_buffer: RTL and testbench

Instruction-fetch stage directly downstream of the PC register: takes the current word address `pc`, issues instruction-memory reads, and queues returned instructions with their PC for decode through a valid/ready handshake. It tolerates multi-cycle memory latency and back-pressure, keeping up to DEPTH fetches in flight or buffered. It discards wrong-path fetches on `flush` (branch/jump redirect).

---
 rtl/ifetch_pkg.sv | 14 +
 rtl/ifb_slot_ring.sv | 59 +++++
 rtl/ifetch_buffer.sv | 80 ++++++++
 tb/tb_ifetch_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types: slot record, word address, reset PC.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef logic [31:2] word_addr_t;

  typedef struct packed {
    word_addr_t  pc;
    logic [31:0] inst;
    logic        filled;
  } ifb_slot_t;

endpackage

// File: rtl/ifb_slot_ring.sv
// Slot ring for the fetch buffer: storage, alloc/fill/read pointers
// and occupancy count.
import ifetch_pkg::*;

module ifb_slot_ring #(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       flag_reset,
  input  logic                       flush,
  input  logic                       issue,
  input  word_addr_t                 issue_pc,
  input  logic                       fill,
  input  logic [31:0]                fill_inst,
  input  logic                       pop,
  output ifb_slot_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] used
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = $clog2(DEPTH+1);

  ifb_slot_t        slots [DEPTH];
  logic [PW-1:0]    alloc_ptr;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (flag_reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (flag_reset) slots[i] <= '0;
        else            slots[i].filled <= 1'b0;
      end
    end else begin
      if (issue) begin
        slots[alloc_ptr].pc     <= issue_pc;
        slots[alloc_ptr].filled <= 1'b0;
        alloc_ptr               <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_ptr].inst   <= fill_inst;
        slots[fill_ptr].filled <= 1'b1;
        fill_ptr               <= fill_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      used <= used + UW'(issue) - UW'(pop);
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues imem reads for pc, buffers returned words in
// order for decode, drops wrong-path responses after a flush.
import ifetch_pkg::*;

module ifetch_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        flag_reset,
  input  word_addr_t  pc,
  input  logic        pc_req,
  output logic        pc_ack,
  output logic        imem_req,
  output word_addr_t  imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output word_addr_t  inst_pc,
  input  logic        flush
);

  localparam int UW = $clog2(DEPTH+1);
  localparam int DW = $clog2(DEPTH+1) + 4;

  logic [UW-1:0] used;
  logic [UW-1:0] pend;
  logic [DW-1:0] drop;
  ifb_slot_t     head;
  logic          issue;
  logic          resp_keep;
  logic          pop;

  assign imem_req   = pc_req && (used < UW'(DEPTH)) && !flush && !flag_reset;
  assign imem_addr  = pc;
  assign issue      = imem_req && imem_gnt;
  assign pc_ack     = issue;
  assign resp_keep  = imem_rvalid && (drop == '0);
  assign inst_valid = (used != '0) && head.filled;
  assign pop        = inst_valid && inst_ready && !flush;
  assign inst       = head.inst;
  assign inst_pc    = head.pc;

  ifb_slot_ring #(.DEPTH(DEPTH)) u_ring (
    .clock     (clock),
    .flag_reset(flag_reset),
    .flush     (flush),
    .issue     (issue),
    .issue_pc  (pc),
    .fill      (resp_keep),
    .fill_inst (imem_rdata),
    .pop       (pop),
    .head      (head),
    .used      (used)
  );

  // pend: live requests owed to the ring; drop: stale ones to discard.
  always_ff @(posedge clock) begin
    if (flag_reset) begin
      pend <= '0;
      drop <= '0;
    end else if (flush) begin
      pend <= '0;
      drop <= drop + DW'(pend) - DW'(imem_rvalid);
    end else begin
      pend <= pend + UW'(issue) - UW'(resp_keep);
      if (imem_rvalid && (drop != '0)) begin
        drop <= drop - DW'(1);
      end
    end
  end

  a_rvalid_owner: assert property (
    @(posedge clock) disable iff (flag_reset)
    imem_rvalid |-> ((pend != '0) || (drop != '0))
  );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench: latency-modelling memory plus an in-order
// expected-fetch queue per flush epoch.
module tb_ifetch_buffer;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        flag_reset = 1'b1;
  word_addr_t  pc = '0;
  logic        pc_req = 1'b0;
  logic        pc_ack;
  logic        imem_req;
  word_addr_t  imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  word_addr_t  inst_pc;
  logic        flush = 1'b0;

  always #5 clock = ~clock;

  ifetch_buffer #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .flag_reset (flag_reset),
    .pc         (pc),
    .pc_req     (pc_req),
    .pc_ack     (pc_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .flush      (flush)
  );

  typedef struct {
    word_addr_t pc;
    bit         ret;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    int          epoch;
    int          due;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mq[$];
  int    cyc = 0;
  int    epoch = 0;
  int    last_due = 0;
  int    gnt_pct = 100;
  int    lat_lo = 1;
  int    lat_hi = 1;
  int    n_chk = 0;
  int    n_pass = 0;

  logic        s_req, s_ack, s_valid;
  logic [31:0] s_inst;
  word_addr_t  s_pc, s_addr;
  logic        e_req, e_ack, e_valid;
  logic [31:0] e_inst;
  word_addr_t  e_pc;

  function automatic logic [31:0] mem_data(word_addr_t a);
    if (a == 30'h0C00) return 32'h2008_0005;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int stale_count();
    int n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) n++;
    return n;
  endfunction

  // Advance one clock: drive memory, sample DUT, update reference.
  task automatic cycle();
    mreq_t m;
    int    d;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    imem_rvalid = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_rdata  = imem_rvalid ? mq[0].data : $urandom;
    #1;
    s_req   = imem_req;
    s_ack   = pc_ack;
    s_valid = inst_valid;
    s_inst  = inst;
    s_pc    = inst_pc;
    s_addr  = imem_addr;
    e_req   = pc_req && !flush && !flag_reset && (exp_q.size() < DEPTH);
    e_ack   = e_req && imem_gnt;
    e_valid = 1'b0;
    e_pc    = '0;
    if (exp_q.size() > 0) begin
      e_valid = exp_q[0].ret;
      e_pc    = exp_q[0].pc;
    end
    e_inst = mem_data(e_pc);
    @(posedge clock);
    if (imem_rvalid) begin
      m = mq.pop_front();
      if (m.epoch == epoch) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].ret) begin
            exp_q[i].ret = 1'b1;
            break;
          end
        end
      end
    end
    if (s_req && imem_gnt && !flag_reset) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{mem_data(s_addr), epoch, d});
      last_due = d;
    end
    if (flag_reset) begin
      mq.delete();
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
      epoch++;
    end else begin
      if (e_valid && inst_ready) void'(exp_q.pop_front());
      if (e_ack) exp_q.push_back('{pc, 1'b0});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    flag_reset = 1'b1;
    flush      = 1'b0;
    pc_req     = 1'b0;
    cycle();
    flag_reset = 1'b0;
  endtask

  task automatic test_reset();
    flag_reset = 1'b1;
    pc_req     = 1'b1;
    pc         = 30'h0C00;
    inst_ready = 1'b1;
    gnt_pct    = 100;
    cycle();
    cycle();
    n_chk++; if (s_req !== 1'b0) $display("FAIL reset_req got %b want 0", s_req); else n_pass++;
    n_chk++; if (s_ack !== 1'b0) $display("FAIL reset_ack got %b want 0", s_ack); else n_pass++;
    n_chk++; if (s_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", s_valid); else n_pass++;
    n_chk++; if (s_inst !== 32'h0) $display("FAIL reset_inst got %h want 0", s_inst); else n_pass++;
    n_chk++; if (s_pc !== 30'h0) $display("FAIL reset_pc got %h want 0", s_pc); else n_pass++;
    n_chk++; if (dut.u_ring.used !== '0) $display("FAIL reset_used got %0d want 0", dut.u_ring.used); else n_pass++;
    n_chk++; if (dut.drop !== '0) $display("FAIL reset_drop got %0d want 0", dut.drop); else n_pass++;
    flag_reset = 1'b0;
  endtask

  task automatic test_first_fetch();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    pc = 30'h0C00; pc_req = 1'b1; inst_ready = 1'b1;
    cycle();
    n_chk++; if (s_ack !== 1'b1) $display("FAIL first_ack got %b want 1", s_ack); else n_pass++;
    pc_req = 1'b0;
    cycle();
    n_chk++; if (s_valid !== 1'b0) $display("FAIL first_valid_c2 got %b want 0", s_valid); else n_pass++;
    cycle();
    n_chk++; if (s_valid !== 1'b1) $display("FAIL first_valid_c3 got %b want 1", s_valid); else n_pass++;
    n_chk++; if (s_pc !== 30'h0C00) $display("FAIL first_pc got %h want 0c00", s_pc); else n_pass++;
    n_chk++; if (s_inst !== 32'h2008_0005) $display("FAIL first_inst got %h want 20080005", s_inst); else n_pass++;
  endtask

  task automatic test_stall();
    word_addr_t acks[$];
    do_reset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    inst_ready = 1'b0; pc_req = 1'b1; pc = 30'h0C00;
    repeat (6) begin
      cycle();
      if (s_ack) begin acks.push_back(pc); pc = pc + 1'b1; end
    end
    n_chk++; if (acks.size() != 2) $display("FAIL stall_grants got %0d want 2", acks.size()); else n_pass++;
    if (acks.size() >= 2) begin
      n_chk++; if (acks[0] !== 30'h0C00) $display("FAIL stall_pc0 got %h want 0c00", acks[0]); else n_pass++;
      n_chk++; if (acks[1] !== 30'h0C01) $display("FAIL stall_pc1 got %h want 0c01", acks[1]); else n_pass++;
    end
    n_chk++; if (s_req !== 1'b0) $display("FAIL stall_req got %b want 0", s_req); else n_pass++;
    n_chk++; if (s_ack !== 1'b0) $display("FAIL stall_ack got %b want 0", s_ack); else n_pass++;
    inst_ready = 1'b1;
    cycle();
    n_chk++; if (s_valid !== 1'b1 || s_pc !== 30'h0C00) $display("FAIL stall_pop got %b/%h want 1/0c00", s_valid, s_pc); else n_pass++;
    inst_ready = 1'b0;
    cycle();
    n_chk++; if (s_req !== 1'b1) $display("FAIL stall_resume_req got %b want 1", s_req); else n_pass++;
  endtask

  task automatic test_delayed();
    word_addr_t issued[$];
    word_addr_t popped[$];
    int bad = 0;
    do_reset();
    lat_lo = 3; lat_hi = 3; gnt_pct = 100;
    inst_ready = 1'b1; pc = word_addr_t'($urandom); pc_req = 1'b1;
    for (int c = 0; c < 300 && popped.size() < 16; c++) begin
      cycle();
      n_chk++; if (s_req !== e_req) $display("FAIL delayed_req got %b want %b", s_req, e_req); else n_pass++;
      n_chk++; if (s_valid !== e_valid) $display("FAIL delayed_valid got %b want %b", s_valid, e_valid); else n_pass++;
      if (e_valid) begin
        popped.push_back(s_pc);
        n_chk++; if (s_inst !== e_inst) $display("FAIL delayed_inst got %h want %h", s_inst, e_inst); else n_pass++;
      end
      if (s_ack) begin
        issued.push_back(pc);
        pc = pc + 1'b1;
        if (issued.size() == 16) pc_req = 1'b0;
      end
    end
    pc_req = 1'b0;
    n_chk++; if (popped.size() != 16) $display("FAIL delayed_count got %0d want 16", popped.size()); else n_pass++;
    foreach (popped[i]) if (i >= issued.size() || popped[i] !== issued[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL delayed_order got %0d misordered want 0", bad); else n_pass++;
  endtask

  task automatic test_flush_stale();
    int acks = 0;
    bit seen = 0;
    do_reset();
    lat_lo = 4; lat_hi = 4; gnt_pct = 100;
    inst_ready = 1'b1; pc = 30'h0C80; pc_req = 1'b1;
    for (int c = 0; c < 10 && acks < 2; c++) begin
      cycle();
      if (s_ack) begin acks++; pc = pc + 1'b1; end
    end
    pc_req = 1'b0; flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_chk++; if (s_req !== 1'b0) $display("FAIL stale_flush_req got %b want 0", s_req); else n_pass++;
    n_chk++; if (int'(dut.drop) != 2) $display("FAIL stale_drop got %0d want 2", dut.drop); else n_pass++;
    pc = 30'h0D00; pc_req = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      cycle();
      if (s_ack) pc_req = 1'b0;
      if (s_valid) begin
        seen = 1;
        n_chk++; if (s_pc !== 30'h0D00) $display("FAIL stale_pc got %h want 0d00", s_pc); else n_pass++;
        n_chk++; if (s_inst !== mem_data(30'h0D00)) $display("FAIL stale_inst got %h want %h", s_inst, mem_data(30'h0D00)); else n_pass++;
      end
    end
    pc_req = 1'b0;
    n_chk++; if (!seen) $display("FAIL stale_timeout got none want inst_valid"); else n_pass++;
  endtask

  task automatic test_flush_collide();
    bit hit = 0;
    int want;
    do_reset();
    lat_lo = 2; lat_hi = 2; gnt_pct = 100;
    inst_ready = 1'b1; pc = 30'h0E00; pc_req = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && exp_q.size() > 0 && exp_q[0].ret) begin
        hit = 1;
        flush = 1'b1;
        pc_req = 1'b0;
      end
      cycle();
      if (s_ack) pc = pc + 1'b1;
    end
    flush = 1'b0;
    pc_req = 1'b0;
    n_chk++; if (!hit) $display("FAIL collide_setup got no overlap want overlap"); else n_pass++;
    want = stale_count();
    n_chk++; if (int'(dut.drop) != want) $display("FAIL collide_drop got %0d want %0d", dut.drop, want); else n_pass++;
    cycle();
    n_chk++; if (s_valid !== 1'b0) $display("FAIL collide_valid got %b want 0", s_valid); else n_pass++;
  endtask

  task automatic test_reset_full();
    bit seen = 0;
    do_reset();
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    inst_ready = 1'b0; pc = 30'h0C40; pc_req = 1'b1;
    repeat (5) begin
      cycle();
      if (s_ack) pc = pc + 1'b1;
    end
    n_chk++; if (dut.u_ring.used !== 2'd2 || s_valid !== 1'b1) $display("FAIL full_before got %0d/%b want 2/1", dut.u_ring.used, s_valid); else n_pass++;
    flag_reset = 1'b1;
    cycle();
    flag_reset = 1'b0; pc_req = 1'b0;
    cycle();
    n_chk++; if (s_valid !== 1'b0) $display("FAIL full_rst_valid got %b want 0", s_valid); else n_pass++;
    n_chk++; if (s_inst !== 32'h0 || s_pc !== 30'h0) $display("FAIL full_rst_data got %h/%h want 0/0", s_inst, s_pc); else n_pass++;
    n_chk++; if (s_ack !== 1'b0 || s_req !== 1'b0) $display("FAIL full_rst_req got %b/%b want 0/0", s_ack, s_req); else n_pass++;
    n_chk++; if (dut.u_ring.used !== '0) $display("FAIL full_rst_used got %0d want 0", dut.u_ring.used); else n_pass++;
    pc = 30'h0F00; pc_req = 1'b1; inst_ready = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (s_ack) pc_req = 1'b0;
      if (s_valid) begin
        seen = 1;
        n_chk++; if (s_pc !== 30'h0F00) $display("FAIL full_resume_pc got %h want 0f00", s_pc); else n_pass++;
      end
    end
    n_chk++; if (!seen) $display("FAIL full_resume_timeout got none want inst_valid"); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 1; lat_hi = 4; gnt_pct = 70;
    pc = word_addr_t'($urandom);
    for (int c = 0; c < 600; c++) begin
      pc_req     = ($urandom_range(99) < 80);
      inst_ready = ($urandom_range(99) < 70);
      flush      = ($urandom_range(99) < 4);
      cycle();
      n_chk++; if (s_req !== e_req) $display("FAIL rand_req c%0d got %b want %b", c, s_req, e_req); else n_pass++;
      n_chk++; if (s_ack !== e_ack) $display("FAIL rand_ack c%0d got %b want %b", c, s_ack, e_ack); else n_pass++;
      n_chk++; if (s_valid !== e_valid) $display("FAIL rand_valid c%0d got %b want %b", c, s_valid, e_valid); else n_pass++;
      if (e_valid) begin
        n_chk++; if (s_pc !== e_pc) $display("FAIL rand_pc c%0d got %h want %h", c, s_pc, e_pc); else n_pass++;
        n_chk++; if (s_inst !== e_inst) $display("FAIL rand_inst c%0d got %h want %h", c, s_inst, e_inst); else n_pass++;
      end
      n_chk++; if (int'(dut.drop) != stale_count()) $display("FAIL rand_drop c%0d got %0d want %0d", c, dut.drop, stale_count()); else n_pass++;
      if (flush) pc = word_addr_t'($urandom);
      else if (s_ack) pc = pc + 1'b1;
    end
    flush = 1'b0;
    pc_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_delayed();
    test_flush_stale();
    test_flush_collide();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
